// File: rtl/result_hex_uart_tx_if.sv
// Result handshake between the ALU datapath and the hex UART reporter.
interface result_hex_uart_tx_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/result_hex_uart_tx.sv
// Sends each accepted result byte as two uppercase hex characters plus CR LF, 8N1 on UART_TXD.
module result_hex_uart_tx #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    result_hex_uart_tx_if.slave   bus,
    output logic                  UART_TXD
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_chk
        $error("result_hex_uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      chr_idx_q, chr_idx_d;
    logic            txd_q, txd_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      chr_c;
    logic [2:0]      bit_nx_c;
    logic            baud_end_c;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + {4'h0, n}) : 8'(8'h37 + {4'h0, n});
    endfunction

    // Character currently on the wire, selected by position in the frame
    always_comb begin
        chr_c = 8'h0A;
        case (chr_idx_q)
            2'd0:    chr_c = hex_char(data_q[7:4]);
            2'd1:    chr_c = hex_char(data_q[3:0]);
            2'd2:    chr_c = 8'h0D;
            default: chr_c = 8'h0A;
        endcase
    end

    assign bit_nx_c   = 3'(bit_q + 3'd1);
    assign baud_end_c = (baud_q == BW'(DIV - 1));

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        chr_idx_d = chr_idx_q;
        txd_d     = txd_q;
        done_d    = 1'b0;

        if (state_q == IDLE) begin
            txd_d = 1'b1;
            if (bus.i_valid) begin
                state_d   = START;
                data_d    = bus.i_data;
                baud_d    = '0;
                bit_d     = '0;
                chr_idx_d = '0;
                txd_d     = 1'b0;
            end
        end else if (baud_end_c) begin
            baud_d = '0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = chr_c[0];
                end
                DATA: begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_nx_c;
                        txd_d = chr_c[bit_nx_c];
                    end
                end
                default: begin
                    if (chr_idx_q == 2'd3) begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        state_d   = START;
                        chr_idx_d = 2'(chr_idx_q + 2'd1);
                        bit_d     = '0;
                        txd_d     = 1'b0;
                    end
                end
            endcase
        end else begin
            baud_d = BW'(baud_q + BW'(1));
            // Flag the last cycle of the final stop bit one edge early so done is a flop
            if (state_q == STOP && chr_idx_q == 2'd3 && baud_q == BW'(DIV - 2))
                done_d = 1'b1;
        end

        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            chr_idx_q <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            chr_idx_q <= chr_idx_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign UART_TXD    = txd_q;
    assign bus.o_ready = ready_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;

endmodule

// File: doc/result_hex_uart_tx.md
# result_hex_uart_tx

Serial reporting stage placed directly downstream of the register-file/ALU datapath in `Mod_Test`. It accepts one 8-bit result per handshake, converts it to two uppercase ASCII hex characters, and appends CR LF. It transmits the 4-character frame on `UART_TXD` as 8N1 serial. A host terminal can then log each ALU result without reading the 7-segment displays.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: bit rate. `DIV = CLK_HZ/BAUD` (integer division, truncated) is the number of clock cycles per bit. `DIV` must be ≥ 2; elaboration fails otherwise.
- `CLOCK_50`, input, 1: the only clock; all logic uses the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `i_valid`, input, 1: `i_data` holds a result to send.
- `i_data`, input, 8: result byte. Sampled only on the acceptance edge.
- `o_ready`, output, 1: high when idle and able to accept.
- `o_busy`, output, 1: always equal to `~o_ready`.
- `o_done`, output, 1: one-cycle pulse in the final cycle of a frame.
- `UART_TXD`, output, 1: serial line; idles high.

## Operation
- **Handshake.** A byte is accepted on a rising edge where `i_valid && o_ready`. At that edge `i_data` is latched, and the block leaves IDLE.
- **No queue.** `i_valid` is ignored while `o_busy`. Any byte presented during a frame is dropped, not queued.
- **Frame.** Four characters are sent in order:
  - `hex(i_data[7:4])`
  - `hex(i_data[3:0])`
  - `8'h0D`
  - `8'h0A`
- **Hex conversion.** A nibble of 0–9 maps to `8'h30 + n`. A nibble of 10–15 maps to `8'h41 + (n − 10)`, giving uppercase A–F.
- **Character format.**
  - Start bit: 0.
  - 8 data bits, LSB first.
  - Stop bit: 1.
  - Each bit is held for exactly `DIV` cycles.
  - There is no idle gap between characters inside a frame.
- **FSM states.**
  - IDLE: `UART_TXD` = 1, `o_ready` = 1.
  - START → DATA, advancing on the bit counter 0..7.
  - DATA → STOP.
  - STOP → START if the character index is < 3; STOP → IDLE if the index is 3.
- **Counters.**
  - Baud counter: `$clog2(DIV)` bits. It counts 0..`DIV`−1 and wraps.
  - Bit counter: 3 bits.
  - Character index: 2 bits.
  - All counters clear on acceptance and on reset.
- **Output register.** `UART_TXD` is driven from a flop, so it is glitch-free.
- **Reset values** (from the cycle after the reset edge):
  - `UART_TXD` = 1
  - `o_ready` = 1
  - `o_busy` = 0
  - `o_done` = 0
  - State = IDLE; latched data = 0.
- **Reset mid-frame.** The frame is aborted immediately. The line returns high on the next cycle, with no partial stop bit. No `o_done` pulse is produced.
- **Reset and valid together.** Reset wins; the byte is not accepted.

## Timing
- Let edge `k` be the acceptance edge.
- Character `n` (0..3) begins at cycle `k+1+10·n·DIV`.
- Within a character, bit `b` occupies cycles `k+1+10·n·DIV+b·DIV` through `+DIV−1`. Bit 0 is the start bit, bits 1–8 are the data bits, and bit 9 is the stop bit.
- The final stop bit ends at cycle `k+40·DIV`. `o_done` is high during that cycle only.
- `o_ready` rises at cycle `k+40·DIV+1`.
- **Back-to-back frames.** If `i_valid` is held high, the next byte is accepted at edge `k+40·DIV+1`. Its start bit begins one cycle later, so exactly one idle-high cycle separates frames.
- Total frame latency is `40·DIV` cycles, plus 1 cycle of re-arm.

## Test plan
All scenarios use `CLK_HZ=1000` and `BAUD=100`, giving `DIV=10`. Bits are sampled at mid-bit.

1. **Reset.** Hold `reset` for 3 cycles with `i_valid` = 1 → `UART_TXD`=1, `o_ready`=1, `o_busy`=0, `o_done`=0, and nothing is accepted.
2. **Digits.** Send `8'h06` → line decodes `8'h30`, `8'h36`, `8'h0D`, `8'h0A`. `o_done` pulses exactly 400 cycles after acceptance, and `o_ready` returns at cycle 401.
3. **Letters and boundary nibbles.** Send `8'hAF` → `8'h41`, `8'h46`, CR, LF. Then send `8'h90` → `8'h39`, `8'h30`, CR, LF.
4. **Drop while busy.** Send `8'h03`, then pulse `i_valid` with `8'hFF` at cycle 50 → only `8'h30`, `8'h33`, CR, LF are sent, and `o_done` pulses once.
5. **Reset mid-frame.** Send `8'h5C` and assert `reset` at cycle 150 → `UART_TXD`=1 and `o_ready`=1 on the next cycle, with no `o_done`. A following send of `8'h12` decodes `8'h31`, `8'h32`, CR, LF.
6. **Back-to-back.** Hold `i_valid` high with `8'h12`, then `8'h34` → two frames separated by exactly one idle-high cycle after the stop bit. `o_done` pulses at cycles 400 and 801 relative to the first acceptance.
